// File: rtl/sw_seq_pkg.sv
// rtl/sw_seq_pkg.sv - shared types, code constants and index wrap helper for the switch sequencer
package sw_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEAD   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam logic [2:0] CODE_OFF = 3'b000;
  localparam logic [2:0] MAX_CODE = 3'd7;

  // Active codes live in 1..last; zero is reserved for all-switches-off.
  function automatic logic [2:0] next_index(input logic [2:0] idx,
                                            input logic       down,
                                            input logic [2:0] last);
    if (down) begin
      return (idx <= 3'd1) ? last : idx - 3'd1;
    end
    return (idx >= last) ? 3'd1 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter flagging the last cycle of an interval
module cycle_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == CNT_W'(1));

endmodule

// File: rtl/switch_state_sequencer.sv
// rtl/switch_state_sequencer.sv - steps the decoder code through 1..N_STATES with dead-time gaps
module switch_state_sequencer
  import sw_seq_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEAD_CYCLES = 8,
  parameter int N_STATES    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic [CNT_W-1:0] period,
  output logic             b2,
  output logic             b1,
  output logic             b0_LSB,
  output logic             step_strobe,
  output logic             dead_active
);

  localparam logic [2:0]       LAST_CODE = (N_STATES > int'(MAX_CODE)) ? MAX_CODE : 3'(N_STATES);
  localparam bit               HAS_DEAD  = (DEAD_CYCLES != 0);
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] code_q, code_d;
  logic       strobe_q, strobe_d;
  logic       dead_q, dead_d;

  logic             tmr_load;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_expire;
  logic             go_active;
  logic             go_dead;
  logic [CNT_W-1:0] period_eff;

  assign period_eff = (period == '0) ? CNT_W'(1) : period;

  cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // Outputs are computed for the state being entered so they register alongside it.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    code_d    = CODE_OFF;
    strobe_d  = 1'b0;
    dead_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_val   = '0;
    go_active = 1'b0;
    go_dead   = 1'b0;

    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (HAS_DEAD) go_dead = 1'b1;
          else          go_active = 1'b1;
        end
        DEAD: begin
          if (tmr_expire) begin
            go_active = 1'b1;
          end else begin
            dead_d = 1'b1;
            tmr_en = 1'b1;
          end
        end
        ACTIVE: begin
          if (tmr_expire) begin
            idx_d = next_index(idx_q, dir, LAST_CODE);
            if (HAS_DEAD) go_dead = 1'b1;
            else          go_active = 1'b1;
          end else begin
            code_d = idx_q;
            tmr_en = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (go_active) begin
      state_d  = ACTIVE;
      code_d   = idx_d;
      strobe_d = 1'b1;
      tmr_load = 1'b1;
      tmr_val  = period_eff;
    end
    if (go_dead) begin
      state_d  = DEAD;
      dead_d   = 1'b1;
      tmr_load = 1'b1;
      tmr_val  = DEAD_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 3'd1;
      code_q   <= CODE_OFF;
      strobe_q <= 1'b0;
      dead_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
      dead_q   <= dead_d;
    end
  end

  assign b2          = code_q[2];
  assign b1          = code_q[1];
  assign b0_LSB      = code_q[0];
  assign step_strobe = strobe_q;
  assign dead_active = dead_q;

endmodule

// File: tb/tb_switch_state_sequencer.sv
// tb/tb_switch_state_sequencer.sv - randomized bench comparing two sequencer builds to a segment-queue model
module tb_switch_state_sequencer;

  localparam int CNT_W = 16;
  localparam int NS    = 6;
  localparam int K_IDLE = 0;
  localparam int K_DEAD = 1;
  localparam int K_ACT  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             dir = 1'b0;
  logic [CNT_W-1:0] period = '0;

  logic b2_a, b1_a, b0_a, strobe_a, dead_a;
  logic b2_z, b1_z, b0_z, strobe_z, dead_z;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  switch_state_sequencer #(.CNT_W(CNT_W), .DEAD_CYCLES(8), .N_STATES(NS)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .period(period),
    .b2(b2_a), .b1(b1_a), .b0_LSB(b0_a), .step_strobe(strobe_a), .dead_active(dead_a)
  );

  switch_state_sequencer #(.CNT_W(CNT_W), .DEAD_CYCLES(0), .N_STATES(NS)) dut_nodead (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .period(period),
    .b2(b2_z), .b1(b1_z), .b0_LSB(b0_z), .step_strobe(strobe_z), .dead_active(dead_z)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Model: the output stream is a queue of per-cycle entries, refilled one segment at a time.
  typedef struct packed {
    logic [2:0] code;
    logic       strobe;
    logic       dead;
    logic [1:0] kind;
  } exp_t;

  exp_t mq[2][$];
  int   midx[2]  = '{1, 1};
  int   mlast[2] = '{K_IDLE, K_IDLE};
  int   dcyc[2]  = '{8, 0};
  exp_t mexp[2]  = '{'0, '0};

  task automatic model_step(input int m);
    exp_t e;
    int   n;
    if (!rst_n || !en) begin
      mq[m].delete();
      mlast[m] = K_IDLE;
      mexp[m]  = '0;
      if (!rst_n) midx[m] = 1;
      return;
    end
    if (mq[m].size() == 0) begin
      if (mlast[m] == K_ACT) begin
        if (dir) midx[m] = (midx[m] == 1) ? NS : midx[m] - 1;
        else     midx[m] = (midx[m] == NS) ? 1 : midx[m] + 1;
      end
      if (mlast[m] == K_DEAD || dcyc[m] == 0) begin
        n = (period == 0) ? 1 : int'(period);
        for (int i = 0; i < n; i++) begin
          e.code = 3'(midx[m]); e.strobe = (i == 0); e.dead = 1'b0; e.kind = 2'(K_ACT);
          mq[m].push_back(e);
        end
      end else begin
        for (int i = 0; i < dcyc[m]; i++) begin
          e.code = 3'd0; e.strobe = 1'b0; e.dead = 1'b1; e.kind = 2'(K_DEAD);
          mq[m].push_back(e);
        end
      end
    end
    mexp[m]  = mq[m].pop_front();
    mlast[m] = int'(mexp[m].kind);
  endtask

  logic [2:0] prev_a = 3'd0;

  task automatic step();
    logic [2:0] code_a, code_z;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    code_a = {b2_a, b1_a, b0_a};
    code_z = {b2_z, b1_z, b0_z};
    check("code_d8", 32'(code_a), 32'(mexp[0].code));
    check("strobe_d8", 32'(strobe_a), 32'(mexp[0].strobe));
    check("dead_d8", 32'(dead_a), 32'(mexp[0].dead));
    check("code_d0", 32'(code_z), 32'(mexp[1].code));
    check("strobe_d0", 32'(strobe_z), 32'(mexp[1].strobe));
    check("dead_d0", 32'(dead_z), 32'(mexp[1].dead));
    check("nz2nz_d8", 32'(prev_a != 0 && code_a != 0 && code_a != prev_a), 32'd0);
    check("range", 32'(code_a > 3'(NS) || code_z > 3'(NS)), 32'd0);
    prev_a = code_a;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; period = 16'd5;
    run(2);
    rst_n = 1'b1;
    run(20);

    en = 1'b1; dir = 1'b0; period = 16'd5;
    run(100);
    dir = 1'b1; period = 16'd3;
    run(70);
    period = 16'd0;
    run(40);

    for (int i = 0; i < 150; i++) begin
      period = ($urandom_range(0, 1) == 0) ? 16'd5 : 16'd2;
      step();
    end

    en = 1'b0; run(3); en = 1'b1; run(30);
    rst_n = 1'b0; run(1); rst_n = 1'b1; run(30);

    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom_range(0, 99) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      if ($urandom_range(0, 9) == 0) period = 16'($urandom_range(0, 6));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
